// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/opcode request channel and result/flags response channel of alu_seq.
// master drives operands and out_ready; slave (the ALU) drives in_ready and the result side.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       opcode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             overflow;
    logic             illegal;

    modport master (
        output in_valid, a, b, opcode, out_ready,
        input  in_ready, out_valid, result, zero, carry, overflow, illegal
    );

    modport slave (
        input  in_valid, a, b, opcode, out_ready,
        output in_ready, out_valid, result, zero, carry, overflow, illegal
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked WIDTH-bit ALU with adc, variable shifts and iterative multiply (enabled by ALU_SEQ_MUL_EN).
// Latency: 1 cycle for single-cycle ops, s+1 for variable shifts, WIDTH+1 for multiply.
// Backpressure: result/flags held in DONE until out_ready; in_ready low while BUSY or while DONE is stalled.
module alu_seq #(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SHL1 = 4'b0101;
    localparam logic [3:0] OP_SHR1 = 4'b0110;
    localparam logic [3:0] OP_EQ   = 4'b0111;
    localparam logic [3:0] OP_SHL  = 4'b1000;
    localparam logic [3:0] OP_SHR  = 4'b1001;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'b1010;
`endif
    localparam logic [3:0] OP_ADC  = 4'b1011;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             ill_q, ill_d;
    logic             carry_q, carry_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
`ifdef ALU_SEQ_MUL_EN
    logic [2*WIDTH-1:0] prod_q, prod_d, prod_nxt;
    logic [WIDTH:0]     mul_sum;
`endif

    logic [WIDTH:0]   sum_ext, diff_ext;
    logic [WIDTH-1:0] sc_res, sh_nxt;
    logic             sc_c, sc_v, sc_ill, sh_bit;
    logic             in_rdy, accept;
    logic [CW-1:0]    shamt;

    always_comb begin
        sum_ext  = {1'b0, bus.a} + {1'b0, bus.b}
                 + {{WIDTH{1'b0}}, (bus.opcode == OP_ADC) & carry_q};
        diff_ext = {1'b0, bus.a} - {1'b0, bus.b};
        sc_res   = '0;
        sc_c     = 1'b0;
        sc_v     = 1'b0;
        sc_ill   = 1'b0;
        case (bus.opcode)
            OP_ADD, OP_ADC: begin
                sc_res = sum_ext[WIDTH-1:0];
                sc_c   = sum_ext[WIDTH];
                sc_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum_ext[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = diff_ext[WIDTH-1:0];
                sc_c   = diff_ext[WIDTH];
                sc_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff_ext[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND:  sc_res = bus.a & bus.b;
            OP_OR:   sc_res = bus.a | bus.b;
            OP_XOR:  sc_res = bus.a ^ bus.b;
            OP_SHL1: begin
                sc_res = {bus.a[WIDTH-2:0], 1'b0};
                sc_c   = bus.a[WIDTH-1];
            end
            OP_SHR1: begin
                sc_res = {1'b0, bus.a[WIDTH-1:1]};
                sc_c   = bus.a[0];
            end
            OP_EQ:   sc_res = {{(WIDTH-1){1'b0}}, bus.a == bus.b};
            // Zero-distance variable shift completes in one cycle with a passthrough.
            OP_SHL, OP_SHR: sc_res = bus.a;
            default: sc_ill = 1'b1;
        endcase
    end

    always_comb begin
        in_rdy  = rst_n && ((state_q == IDLE) || ((state_q == DONE) && bus.out_ready));
        accept  = bus.in_valid && in_rdy;
        shamt   = CW'(bus.b[SHW-1:0]);
        state_d = state_q;
        res_d   = res_q;
        zero_d  = zero_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        ill_d   = ill_q;
        carry_d = carry_q;
        op_d    = op_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        if (op_q == OP_SHL) begin
            sh_nxt = {acc_q[WIDTH-2:0], 1'b0};
            sh_bit = acc_q[WIDTH-1];
        end else begin
            sh_nxt = {1'b0, acc_q[WIDTH-1:1]};
            sh_bit = acc_q[0];
        end
`ifdef ALU_SEQ_MUL_EN
        prod_d   = prod_q;
        mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, acc_q} : '0);
        prod_nxt = {mul_sum, prod_q[WIDTH-1:1]};
`endif

        case (state_q)
            IDLE: ;
            DONE: if (bus.out_ready) state_d = IDLE;
            BUSY: begin
                cnt_d = cnt_q - CW'(1);
`ifdef ALU_SEQ_MUL_EN
                if (op_q == OP_MUL) begin
                    prod_d = prod_nxt;
                    if (cnt_q == CW'(1)) begin
                        state_d = DONE;
                        res_d   = prod_nxt[WIDTH-1:0];
                        zero_d  = (prod_nxt[WIDTH-1:0] == '0);
                        cout_d  = |prod_nxt[2*WIDTH-1:WIDTH];
                        carry_d = |prod_nxt[2*WIDTH-1:WIDTH];
                        ovf_d   = 1'b0;
                        ill_d   = 1'b0;
                    end
                end else
`endif
                begin
                    acc_d = sh_nxt;
                    if (cnt_q == CW'(1)) begin
                        state_d = DONE;
                        res_d   = sh_nxt;
                        zero_d  = (sh_nxt == '0);
                        cout_d  = sh_bit;
                        carry_d = sh_bit;
                        ovf_d   = 1'b0;
                        ill_d   = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // accept is only possible from IDLE/DONE, so it never collides with the BUSY step.
        if (accept) begin
            op_d  = bus.opcode;
            acc_d = bus.a;
            if (((bus.opcode == OP_SHL) || (bus.opcode == OP_SHR)) && (shamt != '0)) begin
                state_d = BUSY;
                cnt_d   = shamt;
            end
`ifdef ALU_SEQ_MUL_EN
            else if (bus.opcode == OP_MUL) begin
                state_d = BUSY;
                cnt_d   = CW'(WIDTH);
                prod_d  = {{WIDTH{1'b0}}, bus.b};
            end
`endif
            else begin
                state_d = DONE;
                res_d   = sc_res;
                zero_d  = (sc_res == '0);
                cout_d  = sc_c;
                ovf_d   = sc_v;
                ill_d   = sc_ill;
                if (!sc_ill) carry_d = sc_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            res_q   <= '0;
            zero_q  <= 1'b1;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            ill_q   <= 1'b0;
            carry_q <= 1'b0;
            op_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
`ifdef ALU_SEQ_MUL_EN
            prod_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            ill_q   <= ill_d;
            carry_q <= carry_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
`ifdef ALU_SEQ_MUL_EN
            prod_q  <= prod_d;
`endif
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = res_q;
    assign bus.zero      = zero_q;
    assign bus.carry     = cout_q;
    assign bus.overflow  = ovf_q;
    assign bus.illegal   = ill_q;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=8: a behavioural model queues expected results at
// acceptance; a negedge monitor checks latency, flags, hold stability and in_ready.
`timescale 1ns/1ps
module tb_alu_seq;
    localparam int W    = 8;
    localparam int SW   = $clog2(W);
    localparam int MAXS = (1 << (W - 1)) - 1;
    localparam int MINS = -(1 << (W - 1));

    typedef struct {
        logic [W-1:0] res;
        logic         z, c, v, ill;
        int           lat, acc, due;
        string        tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W)) bus ();
    alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   bp_mode = 0;
    logic cq_m  = 1'b0;
    exp_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic cin);
        exp_t e;
        int s, sa, sb_i, sr;
        logic [W:0] full;
        logic [2*W-1:0] p;
        e.res = '0; e.c = 1'b0; e.v = 1'b0; e.ill = 1'b0; e.lat = 1;
        e.acc = 0; e.due = 0; e.tag = "";
        sa = $signed(a); sb_i = $signed(b);
        s = int'(b[SW-1:0]);
        case (op)
            4'h0, 4'hB: begin
                full  = a + b + ((op == 4'hB) ? cin : 1'b0);
                e.res = full[W-1:0];
                e.c   = full[W];
                sr    = sa + sb_i + ((op == 4'hB && cin) ? 1 : 0);
                e.v   = (sr > MAXS) || (sr < MINS);
            end
            4'h1: begin
                e.res = a - b;
                e.c   = (a < b);
                sr    = sa - sb_i;
                e.v   = (sr > MAXS) || (sr < MINS);
            end
            4'h2: e.res = a & b;
            4'h3: e.res = a | b;
            4'h4: e.res = a ^ b;
            4'h5: begin e.res = a << 1; e.c = a[W-1]; end
            4'h6: begin e.res = a >> 1; e.c = a[0]; end
            4'h7: e.res = (a == b) ? 1 : 0;
            4'h8: begin e.lat = s + 1; e.res = a << s; e.c = (s == 0) ? 1'b0 : a[W-s]; end
            4'h9: begin e.lat = s + 1; e.res = a >> s; e.c = (s == 0) ? 1'b0 : a[s-1]; end
`ifdef ALU_SEQ_MUL_EN
            4'hA: begin
                p = a * b;
                e.res = p[W-1:0];
                e.c   = (p[2*W-1:W] != 0);
                e.lat = W + 1;
            end
`endif
            default: e.ill = 1'b1;
        endcase
        e.z = (e.res == 0);
        return e;
    endfunction

    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input string tag);
        exp_t e;
        int n;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.opcode = op; bus.a = a; bus.b = b;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            check({tag, "_accept_timeout"}, bus.in_ready, 1);
            bus.in_valid = 1'b0;
            return;
        end
        e = model(op, a, b, cq_m);
        e.tag = tag;
        e.acc = cyc + 1;
        e.due = cyc + e.lat;
        if (!e.ill) cq_m = e.c;
        sb.push_back(e);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_in_ready"},  bus.in_ready,  0);
        check({tag, "_result"},    bus.result,    0);
        check({tag, "_zero"},      bus.zero,      1);
        check({tag, "_carry"},     bus.carry,     0);
        check({tag, "_overflow"},  bus.overflow,  0);
        check({tag, "_illegal"},   bus.illegal,   0);
    endtask

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (bp_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    initial begin
        exp_t e;
        bit new_res;
        new_res = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                new_res = 1'b1;
            end else if (sb.size() == 0) begin
                check("idle_out_valid", bus.out_valid, 0);
                new_res = 1'b1;
            end else begin
                e = sb[0];
                if (bus.out_valid) begin
                    if (new_res) check({e.tag, "_latency"}, cyc, e.due);
                    check({e.tag, "_result"},   bus.result,   e.res);
                    check({e.tag, "_zero"},     bus.zero,     e.z);
                    check({e.tag, "_carry"},    bus.carry,    e.c);
                    check({e.tag, "_overflow"}, bus.overflow, e.v);
                    check({e.tag, "_illegal"},  bus.illegal,  e.ill);
                    if (!bus.out_ready) check({e.tag, "_hold_in_ready"}, bus.in_ready, 0);
                    else void'(sb.pop_front());
                    new_res = bus.out_ready;
                end else begin
                    if (cyc >= e.acc) check({e.tag, "_busy_in_ready"}, bus.in_ready, 0);
                    new_res = 1'b1;
                end
            end
        end
    end

    initial begin
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.opcode = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2 check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        send(4'h0, 8'hFF, 8'h01, "add_ff_01");
        send(4'hB, 8'h00, 8'h00, "adc_carry_in");
        send(4'h1, 8'h80, 8'h01, "sub_ovf");
        send(4'h1, 8'h01, 8'h02, "sub_borrow");
        send(4'h0, 8'h7F, 8'h01, "add_ovf");
        drain();
        send(4'h8, 8'h81, 8'h03, "shl_3");
        send(4'h9, 8'h81, 8'h00, "shr_0");
        send(4'h9, 8'h81, 8'h07, "shr_7");
        drain();
        send(4'hA, 8'h10, 8'h20, "mul_10_20");
        send(4'hA, 8'h0F, 8'h0D, "mul_0f_0d");
        drain();
        send(4'hC, 8'h12, 8'h34, "illegal_c");
        send(4'hB, 8'h01, 8'h01, "adc_after_ill");
        send(4'h7, 8'h5A, 8'h5A, "eq_true");
        send(4'h7, 8'h5A, 8'h5B, "eq_false");
        send(4'h5, 8'h81, 8'h00, "shl1");
        send(4'h6, 8'h81, 8'h00, "shr1");
        send(4'h3, 8'hA0, 8'h05, "or");
        send(4'h4, 8'hFF, 8'hFF, "xor_zero");
        drain();

        bp_mode = 2;
        send(4'h2, 8'hF0, 8'h3C, "and_bp");
        fork
            send(4'h0, 8'h02, 8'h03, "add_after_bp");
            begin
                repeat (5) @(negedge clk);
                bp_mode = 0;
            end
        join
        drain();

        bp_mode = 1;
        for (int i = 0; i < 40; i++)
            send(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), $sformatf("rnd%0d", i));
        bp_mode = 0;
        drain();

`ifdef ALU_SEQ_MUL_EN
        send(4'hA, 8'h33, 8'h44, "mul_aborted");
`else
        send(4'h8, 8'hFF, 8'h07, "shl_aborted");
`endif
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("mid_op_reset");
        sb.delete();
        cq_m = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (12) @(negedge clk);
        send(4'h0, 8'h02, 8'h03, "add_post_reset");
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the team's 8-bit combinational ALU.
- Operand width is set by a parameter. Operands and opcode arrive on a valid/ready input channel; results and flags leave on a valid/ready output channel.
- Adds multi-cycle operations: variable shift and iterative multiply. Adds add-with-carry using an internal carry flag.
- Sits between the register-file read stage and the writeback stage of the team's small datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 4..32.
- SHW, $clog2(WIDTH), width of the shift-amount field taken from b[SHW-1:0]; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand/opcode valid
- in_ready  output  1  block can accept an operation this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B (shift amount in b[SHW-1:0] for variable shifts)
- opcode  input  4  operation select
- out_valid  output  1  result/flags valid
- out_ready  input  1  consumer accepts the result
- result  output  WIDTH  result
- zero  output  1  result == 0
- carry  output  1  carry / borrow / shifted-out bit / multiply high-half nonzero
- overflow  output  1  signed overflow (add/sub/adc only; 0 otherwise)
- illegal  output  1  opcode unsupported; result 0, all other flags 0 except zero=1

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=IDLE.
  - out_valid, result, carry, overflow and illegal all 0; zero=1.
  - Internal carry_q=0.
  - in_ready is 0 while rst_n is low.
  - Reset mid-operation aborts the operation; no result is produced.
- FSM states: IDLE, BUSY, DONE.
- Handshakes:
  - An operation is accepted when in_valid && in_ready.
  - in_ready = (state==IDLE) || (state==DONE && out_ready), so back-to-back single-cycle ops run at 1 per cycle.
  - In DONE, result and all flags stay stable until out_valid && out_ready.
  - out_valid stays 1 for as long as the block is in DONE.
- Single-cycle ops: operation accepted at edge T enters DONE with out_valid=1 after edge T+1.
  - 0000 add: {carry,result}=a+b.
  - 0001 sub: {carry,result}=a-b, so carry=1 when a<b (borrow).
  - 0010 and; 0011 or; 0100 xor.
  - 0101 shl1: carry=a[WIDTH-1].
  - 0110 shr1: carry=a[0].
  - 0111 eq: result={WIDTH-1 zeros, a==b}.
  - 1011 adc: {carry,result}=a+b+carry_q, where carry_q is sampled at acceptance.
- Variable shifts (1000 shl, 1001 shr): go to BUSY; shift one bit per cycle, repeated s times where s=b[SHW-1:0].
  - out_valid is asserted s+1 cycles after acceptance.
  - s=0 behaves as a single-cycle op: result=a, carry=0.
  - carry = the last bit shifted out.
- Multiply (1010): shift-add, one partial product per cycle, WIDTH cycles in BUSY.
  - out_valid is asserted WIDTH+1 cycles after acceptance.
  - result = low WIDTH bits of the unsigned product.
  - carry = (high WIDTH bits != 0).
- Illegal opcodes (1100-1111, and 1010 when the multiplier is compiled out): single-cycle; illegal=1, result=0.
- Flags:
  - zero is computed from the final result for every op.
  - overflow is set for add/adc/sub on signed overflow of a and b as two's complement; 0 for every other op.
  - carry_q <= carry on every transition into DONE. It is not updated by illegal ops.
- Input sampling: inputs are sampled only at acceptance. Changes to a, b or opcode while BUSY are ignored. in_valid while BUSY is not accepted.

Optional Feature:
- Macro ALU_SEQ_MUL_EN.
- Defined: opcode 1010 performs the iterative multiply described above.
- Undefined: no multiply datapath is instantiated, and 1010 is handled as an illegal opcode (single-cycle, illegal=1, result=0, zero=1).

Test Plan (WIDTH=8):
- add a=0xFF, b=0x01, out_ready=1 -> out_valid 1 cycle later: result=0x00, zero=1, carry=1, overflow=0. Then adc a=0x00, b=0x00 -> result=0x01, carry=0.
- sub a=0x80, b=0x01 -> result=0x7F, carry=0, overflow=1. Then sub a=0x01, b=0x02 -> result=0xFF, carry=1.
- shl a=0x81, b=3 -> in_ready=0 for the BUSY cycles; out_valid 4 cycles after acceptance; result=0x08, carry=0. Also shr a=0x81, b=0 -> result=0x81 after 1 cycle.
- mul a=0x10, b=0x20 with ALU_SEQ_MUL_EN defined -> out_valid 9 cycles after acceptance; result=0x00, carry=1, zero=1. Without the macro -> illegal=1, result=0 after 1 cycle.
- Backpressure: out_ready=0 for 5 cycles after an and of a=0xF0, b=0x3C -> result=0x30 held stable and in_ready=0 throughout. Raise out_ready while in_valid is held high -> next op accepted in the same cycle.
- rst_n pulsed low mid-multiply -> all outputs at reset values immediately; no out_valid afterwards; the next add of 0x02+0x03 gives 0x05 after 1 cycle.
